// File: rtl/allpass_bank_if.sv
// rtl/allpass_bank_if.sv - sample stream and channel config bundle for allpass_bank
interface allpass_bank_if #(
    parameter int WORD  = 32,
    parameter int CH_W  = 2,
    parameter int TAU_W = 10
);
    logic                    in_valid;
    logic                    in_ready;
    logic [CH_W-1:0]         in_ch;
    logic signed [WORD-1:0]  in_data;
    logic                    out_valid;
    logic                    out_ready;
    logic [CH_W-1:0]         out_ch;
    logic signed [WORD-1:0]  out_data;
    logic                    cfg_we;
    logic [CH_W-1:0]         cfg_ch;
    logic [TAU_W-1:0]        cfg_tau;
    logic signed [WORD-1:0]  cfg_gain;

    modport master (
        output in_valid, in_ch, in_data, out_ready, cfg_we, cfg_ch, cfg_tau, cfg_gain,
        input  in_ready, out_valid, out_ch, out_data
    );

    modport slave (
        input  in_valid, in_ch, in_data, out_ready, cfg_we, cfg_ch, cfg_tau, cfg_gain,
        output in_ready, out_valid, out_ch, out_data
    );
endinterface

// File: rtl/allpass_bank.sv
// rtl/allpass_bank.sv - N-channel time-multiplexed Schroeder all-pass over one shared delay RAM
// Optional saturation of v/y and the sat_flag port: define ALLPASS_BANK_SAT_EN.
module allpass_bank #(
    parameter int WIDTH       = 24,
    parameter int FIXED_POINT = 8,
    parameter int N_CH        = 4,
    parameter int MAXLEN      = 1024
) (
    input  logic           clk,
    input  logic           rst,
    allpass_bank_if.slave  bus
`ifdef ALLPASS_BANK_SAT_EN
    ,
    output logic           sat_flag
`endif
);
    localparam int WORD  = WIDTH + FIXED_POINT;
    localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int TAU_W = $clog2(MAXLEN);
    localparam int DEPTH = N_CH * MAXLEN;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic signed [WORD-1:0] ONE = WORD'(1) << FIXED_POINT;
`ifdef ALLPASS_BANK_SAT_EN
    localparam logic signed [WORD-1:0] MAXV = {1'b0, {(WORD-1){1'b1}}};
    localparam logic signed [WORD-1:0] MINV = {1'b1, {(WORD-1){1'b0}}};
`endif

    typedef enum logic [2:0] {S_CLR, S_IDLE, S_RD, S_CALC, S_WR, S_OUT} state_t;
    state_t state, state_nxt;

    logic [AW-1:0]          clr_addr;
    logic [TAU_W-1:0]       wptr   [N_CH];
    logic [TAU_W-1:0]       sh_tau [N_CH];
    logic signed [WORD-1:0] sh_g   [N_CH];
    logic signed [WORD-1:0] sh_g2  [N_CH];

    // cur_* hold the active configuration and sample for the channel in flight
    logic [CH_W-1:0]        cur_ch;
    logic signed [WORD-1:0] cur_in, cur_g, cur_g2;
    logic [TAU_W-1:0]       cur_tau;
    logic signed [WORD-1:0] rd_data, v_r, out_data_r;
    logic [CH_W-1:0]        out_ch_r;

    logic [WORD-1:0]        mem [DEPTH];
    logic                   mem_we;
    logic [AW-1:0]          mem_waddr, rd_addr;
    logic [WORD-1:0]        mem_wdata;
    logic [TAU_W-1:0]       rd_off, cfg_tau_fix;

    logic                   in_ch_ok, cfg_ok, bypass;
    logic signed [2*WORD-1:0] g_sq, p_gx, p_ngin, p_g2x;
    logic signed [WORD:0]   v_sum, y_sum;
    logic signed [WORD-1:0] cfg_g2;

    function automatic logic signed [WORD-1:0] reduce(input logic signed [WORD:0] s);
`ifdef ALLPASS_BANK_SAT_EN
        if (s[WORD] != s[WORD-1]) return s[WORD] ? MINV : MAXV;
`endif
        return WORD'(s);
    endfunction

    assign in_ch_ok    = int'(bus.in_ch) < N_CH;
    assign cfg_ok      = bus.cfg_we && (int'(bus.cfg_ch) < N_CH);
    assign bypass      = cfg_ok && (bus.cfg_ch == bus.in_ch);
    assign cfg_tau_fix = (bus.cfg_tau == '0) ? TAU_W'(1) : bus.cfg_tau;
    assign g_sq        = bus.cfg_gain * bus.cfg_gain;
    assign cfg_g2      = ONE - WORD'(g_sq >>> FIXED_POINT);

    assign p_gx   = cur_g * rd_data;
    assign p_ngin = -(cur_g * cur_in);
    assign p_g2x  = cur_g2 * rd_data;
    assign v_sum  = (WORD+1)'(cur_in) + (WORD+1)'(p_gx >>> FIXED_POINT);
    assign y_sum  = (WORD+1)'(p_ngin >>> FIXED_POINT) + (WORD+1)'(p_g2x >>> FIXED_POINT);

    // tap offset wraps naturally in TAU_W bits because MAXLEN is a power of two
    assign rd_off    = wptr[cur_ch] - cur_tau;
    assign rd_addr   = AW'({cur_ch, rd_off});
    assign mem_we    = (state == S_CLR) || (state == S_WR);
    assign mem_waddr = (state == S_CLR) ? clr_addr : AW'({cur_ch, wptr[cur_ch]});
    assign mem_wdata = (state == S_CLR) ? '0 : v_r;

    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
        rd_data <= mem[rd_addr];
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_CLR;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        bus.in_ready = 1'b0;
        bus.out_valid = 1'b0;
        case (state)
            S_CLR:  if (clr_addr == AW'(DEPTH - 1)) state_nxt = S_IDLE;
            S_IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid && in_ch_ok) state_nxt = S_RD;
            end
            S_RD:   state_nxt = S_CALC;
            S_CALC: state_nxt = S_WR;
            S_WR:   state_nxt = S_OUT;
            S_OUT: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_CLR;
        endcase
    end

    assign bus.out_ch   = out_ch_r;
    assign bus.out_data = out_data_r;

`ifdef ALLPASS_BANK_SAT_EN
    logic clip_r;
    assign sat_flag = (state == S_WR) && clip_r;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            clr_addr   <= '0;
            for (int i = 0; i < N_CH; i++) begin
                wptr[i]   <= '0;
                sh_tau[i] <= TAU_W'(1);
                sh_g[i]   <= '0;
                sh_g2[i]  <= ONE;
            end
            cur_ch     <= '0;
            cur_in     <= '0;
            cur_tau    <= TAU_W'(1);
            cur_g      <= '0;
            cur_g2     <= ONE;
            v_r        <= '0;
            out_data_r <= '0;
            out_ch_r   <= '0;
`ifdef ALLPASS_BANK_SAT_EN
            clip_r     <= 1'b0;
`endif
        end else begin
            if (state == S_CLR) clr_addr <= clr_addr + 1'b1;
            if (cfg_ok) begin
                sh_tau[bus.cfg_ch] <= cfg_tau_fix;
                sh_g[bus.cfg_ch]   <= bus.cfg_gain;
                sh_g2[bus.cfg_ch]  <= cfg_g2;
            end
            // a config write landing on the accept cycle is used by that very sample
            if (state == S_IDLE && bus.in_valid && in_ch_ok) begin
                cur_ch  <= bus.in_ch;
                cur_in  <= bus.in_data;
                cur_tau <= bypass ? cfg_tau_fix  : sh_tau[bus.in_ch];
                cur_g   <= bypass ? bus.cfg_gain : sh_g[bus.in_ch];
                cur_g2  <= bypass ? cfg_g2       : sh_g2[bus.in_ch];
            end
            if (state == S_CALC) begin
                v_r        <= reduce(v_sum);
                out_data_r <= reduce(y_sum);
                out_ch_r   <= cur_ch;
`ifdef ALLPASS_BANK_SAT_EN
                clip_r     <= (v_sum[WORD] != v_sum[WORD-1]) || (y_sum[WORD] != y_sum[WORD-1]);
`endif
            end
            if (state == S_WR) wptr[cur_ch] <= wptr[cur_ch] + 1'b1;
        end
    end
endmodule

// File: tb/tb_allpass_bank.sv
// tb/tb_allpass_bank.sv - directed bench for allpass_bank with hand-computed responses
module tb_allpass_bank;
    localparam int WIDTH = 24, FP = 8, N_CH = 3, MAXLEN = 1024;
    localparam int WORD = WIDTH + FP, CH_W = 2, TAU_W = 10;
    localparam int K = N_CH * MAXLEN;
    localparam logic signed [WORD-1:0] MAXP = 32'sh7fffffff;
`ifdef ALLPASS_BANK_SAT_EN
    localparam logic signed [WORD-1:0] P_Y2 = -32'sd1509949441;
    localparam logic signed [WORD-1:0] N_Y1 = MAXP;
`else
    localparam logic signed [WORD-1:0] P_Y2 = -32'sd1971978241;
    localparam logic signed [WORD-1:0] N_Y1 = -32'sd1946157058;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    allpass_bank_if #(.WORD(WORD), .CH_W(CH_W), .TAU_W(TAU_W)) bus();
`ifdef ALLPASS_BANK_SAT_EN
    logic sat_flag;
`endif

    allpass_bank #(.WIDTH(WIDTH), .FIXED_POINT(FP), .N_CH(N_CH), .MAXLEN(MAXLEN)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef ALLPASS_BANK_SAT_EN
        ,
        .sat_flag(sat_flag)
`endif
    );

    int checks = 0;
    int errors = 0;
    logic mid_en = 1'b0, byp_en = 1'b0, sat_seen = 1'b0;
    logic [CH_W-1:0] aux_ch;
    logic [TAU_W-1:0] aux_tau;
    logic signed [WORD-1:0] aux_gain;
    int exp1 [12] = '{-128, 0, 0, 192, 0, 0, 96, 0, 96, 0, 0, 48};

    task automatic check(input string tag, input logic signed [WORD-1:0] obs,
                         input logic signed [WORD-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic cfg(input logic [CH_W-1:0] ch, input logic [TAU_W-1:0] tau,
                       input logic signed [WORD-1:0] g);
        bus.cfg_we = 1'b1; bus.cfg_ch = ch; bus.cfg_tau = tau; bus.cfg_gain = g;
        cycle();
        bus.cfg_we = 1'b0;
    endtask

    task automatic wait_clr(input string tag, input int pre);
        repeat (K - 1 - pre) cycle();
        check({tag, "_rdy_early"}, bus.in_ready, 0);
        check({tag, "_data_clr"}, bus.out_data, 0);
        check({tag, "_valid_clr"}, bus.out_valid, 0);
        cycle();
        check({tag, "_rdy_rise"}, bus.in_ready, 1);
    endtask

    task automatic send(input logic [CH_W-1:0] ch, input logic signed [WORD-1:0] din,
                        input int stall, input logic signed [WORD-1:0] expy, input string tag);
        int n = 0;
        int lat = 1;
        logic ok = 1'b1;
        logic signed [WORD-1:0] d0;
        bus.in_valid = 1'b1; bus.in_ch = ch; bus.in_data = din;
        if (byp_en) begin
            bus.cfg_we = 1'b1; bus.cfg_ch = aux_ch; bus.cfg_tau = aux_tau; bus.cfg_gain = aux_gain;
        end
        while (!bus.in_ready && n < 20) begin cycle(); n++; end
        cycle();
        bus.in_valid = 1'b0; bus.in_data = 32'sh5a5a5a5a; bus.cfg_we = 1'b0; byp_en = 1'b0;
        sat_seen = 1'b0;
        while (!bus.out_valid && lat < 20) begin
            if (mid_en) begin
                bus.cfg_we = 1'b1; bus.cfg_ch = aux_ch; bus.cfg_tau = aux_tau; bus.cfg_gain = aux_gain;
                mid_en = 1'b0;
            end
            cycle();
            bus.cfg_we = 1'b0;
            lat++;
`ifdef ALLPASS_BANK_SAT_EN
            sat_seen = sat_seen | sat_flag;
`endif
        end
        check({tag, "_lat"}, lat, 4);
        d0 = bus.out_data;
        if (stall > 0) begin
            bus.out_ready = 1'b0;
            repeat (stall) begin
                cycle();
                ok = ok & (bus.out_valid === 1'b1) & (bus.out_data === d0) & (bus.in_ready === 1'b0);
            end
            bus.out_ready = 1'b1;
            check({tag, "_stall"}, ok, 1);
        end
        check({tag, "_y"}, bus.out_data, expy);
        check({tag, "_ch"}, bus.out_ch, ch);
        cycle();
        check({tag, "_drop"}, bus.out_valid, 0);
    endtask

    initial begin
        logic ok;
        bus.in_valid = 1'b0; bus.in_ch = '0; bus.in_data = '0; bus.out_ready = 1'b1;
        bus.cfg_we = 1'b0; bus.cfg_ch = '0; bus.cfg_tau = '0; bus.cfg_gain = '0;
        repeat (3) cycle();
        rst = 1'b0;
        check("rst_ready", bus.in_ready, 0);
        check("rst_valid", bus.out_valid, 0);
        check("rst_data", bus.out_data, 0);
        check("rst_ch", bus.out_ch, 0);
        cfg(2'd1, 10'd3, 32'sd128);
        wait_clr("clr", 1);

        send(2'd0, 32'sd256, 0, 0, "ch0_imp0");
        send(2'd0, 32'sd0, 0, 256, "ch0_imp1");
        send(2'd0, 32'sd0, 0, 0, "ch0_imp2");
        send(2'd0, 32'sd0, 0, 0, "ch0_imp3");

        for (int n = 0; n < 12; n++) begin
            if (n == 6) begin
                mid_en = 1'b1; aux_ch = 2'd1; aux_tau = 10'd5; aux_gain = 32'sd128;
            end
            send(2'd1, (n == 0) ? 32'sd256 : 32'sd0, (n == 3) ? 10 : 0, exp1[n],
                 $sformatf("ch1_n%0d", n));
            if (n < 6) begin
                send(2'd0, 32'sd0, 0, 0, "ch0_il");
                send(2'd2, 32'sd0, 0, 0, "ch2_il");
            end
        end

        send(2'd0, 32'sd100, 0, 0, "ch0_pre");
        cfg(2'd3, 10'd7, 32'sd5000);
        bus.in_valid = 1'b1; bus.in_ch = 2'd3; bus.in_data = 32'sd777;
        cycle();
        bus.in_valid = 1'b0;
        check("oor_ready", bus.in_ready, 1);
        ok = 1'b1;
        repeat (8) begin cycle(); ok = ok & (bus.out_valid === 1'b0); end
        check("oor_no_out", ok, 1);
        send(2'd0, 32'sd0, 0, 100, "ch0_post");

        byp_en = 1'b1; aux_ch = 2'd2; aux_tau = 10'd1; aux_gain = 32'sd128;
        send(2'd2, 32'sd256, 0, -128, "bypass");

        bus.in_valid = 1'b1; bus.in_ch = 2'd0; bus.in_data = 32'sd1234;
        cycle();
        bus.in_valid = 1'b0;
        cycle();
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
        check("rst2_valid", bus.out_valid, 0);
        check("rst2_data", bus.out_data, 0);
        check("rst2_ready", bus.in_ready, 0);
        wait_clr("rst2", 0);
        send(2'd1, 32'sd256, 0, 0, "ch1_dflt0");
        send(2'd1, 32'sd0, 0, 256, "ch1_dflt1");

        cfg(2'd0, 10'd1, 32'sd230);
        send(2'd0, MAXP, 0, -32'sd1929379840, "satp0");
`ifdef ALLPASS_BANK_SAT_EN
        check("satp0_flag", sat_seen, 0);
`endif
        send(2'd0, MAXP, 0, -32'sd1509949441, "satp1");
`ifdef ALLPASS_BANK_SAT_EN
        check("satp1_flag", sat_seen, 1);
`endif
        send(2'd0, MAXP, 0, P_Y2, "satp2");

        cfg(2'd2, 10'd0, -32'sd230);
        send(2'd2, MAXP, 0, 32'sd1929379839, "satn0");
        send(2'd2, MAXP, 0, N_Y1, "satn1");
`ifdef ALLPASS_BANK_SAT_EN
        check("satn1_flag", sat_seen, 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
